// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back register file with bypassed reads, retire counter and readout scanner
//
// Ports:
//   clk, startin_n                 clock, synchronous active-low reset
//   WB_reg_write, WB_mem_to_reg    write-back enable and write-data select (1 = memory data)
//   WB_mem_data, WB_alu_result     write-back data candidates
//   WB_mux_out                     destination register index
//   ID_rs, ID_rt                   decode-stage read indices
//   ID_rs_data, ID_rt_data         combinational read data with write-back bypass
//   WB_write_data                  selected write-back value
//   retire_count                   count of write-back cycles (wraps)
//   dump_req                       start a full register-file readout
//   dump_busy                      readout in progress
//   dump_valid, dump_addr, dump_data  registered readout beat
//   dump_done                      one-cycle pulse after the last beat
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              startin_n,
  input  logic              WB_reg_write,
  input  logic              WB_mem_to_reg,
  input  logic [DATA_W-1:0] WB_mem_data,
  input  logic [DATA_W-1:0] WB_alu_result,
  input  logic [ADDR_W-1:0] WB_mux_out,
  input  logic [ADDR_W-1:0] ID_rs,
  input  logic [ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0] ID_rs_data,
  output logic [DATA_W-1:0] ID_rt_data,
  output logic [DATA_W-1:0] WB_write_data,
  output logic [31:0]       retire_count,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_hit;
  logic [DATA_W-1:0] scan_data;
  logic [31:0]       retire_q;
  state_t            state;
  logic [ADDR_W-1:0] idx;

  assign WB_write_data = WB_mem_to_reg ? WB_mem_data : WB_alu_result;

  // Index 0 is hard-wired to zero, so a write aimed at it neither lands nor bypasses.
  assign wr_hit = WB_reg_write && (WB_mux_out != '0);

  assign ID_rs_data = (wr_hit && (ID_rs == WB_mux_out)) ? WB_write_data : regs[ID_rs];
  assign ID_rt_data = (wr_hit && (ID_rt == WB_mux_out)) ? WB_write_data : regs[ID_rt];
  assign scan_data  = (wr_hit && (idx   == WB_mux_out)) ? WB_write_data : regs[idx];

  assign retire_count = retire_q;

  always_ff @(posedge clk) begin
    if (!startin_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[WB_mux_out] <= WB_write_data;
    end
  end

  // Counts every write-back cycle, including the discarded writes to index 0.
  always_ff @(posedge clk) begin
    if (!startin_n) begin
      retire_q <= '0;
    end else if (WB_reg_write) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  // Readout scanner. dump_busy stays high for one IDLE cycle after the last beat;
  // that cycle emits dump_done. A request is only accepted once busy and done are both low,
  // so a request during the scan or during the done cycle is dropped.
  always_ff @(posedge clk) begin
    if (!startin_n) begin
      state      <= IDLE;
      idx        <= '0;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          dump_valid <= 1'b0;
          if (dump_busy) begin
            dump_busy <= 1'b0;
            dump_done <= 1'b1;
          end else if (dump_req && !dump_done) begin
            state     <= SCAN;
            idx       <= '0;
            dump_busy <= 1'b1;
          end
        end
        SCAN: begin
          dump_valid <= 1'b1;
          dump_addr  <= idx;
          dump_data  <= scan_data;
          idx        <= idx + IDX_ONE;
          if (idx == '1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: DATA_W, default 32, datapath and register width.
REQ-002 Parameter: ADDR_W, default 5, register index width; register count 2^ADDR_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 startin_n  in  1  reset, synchronous, active-low.
REQ-005 WB_reg_write  in  1  write enable from the MEM/WB stage register.
REQ-006 WB_mem_to_reg  in  1  write-data select: 1 = memory data, 0 = ALU result.
REQ-007 WB_mem_data  in  DATA_W  load data from the MEM/WB stage register.
REQ-008 WB_alu_result  in  DATA_W  ALU result from the MEM/WB stage register.
REQ-009 WB_mux_out  in  ADDR_W  destination register index.
REQ-010 ID_rs, ID_rt  in  ADDR_W each  decode-stage read indices.
REQ-011 ID_rs_data, ID_rt_data  out  DATA_W each  combinational read data.
REQ-012 WB_write_data  out  DATA_W  selected write-back value, combinational.
REQ-013 retire_count  out  32  registered count of write-back cycles.
REQ-014 dump_req  in  1  request a full register-file readout.
REQ-015 dump_busy  out  1  high while a readout is in progress.
REQ-016 dump_valid, dump_addr (ADDR_W), dump_data (DATA_W)  out  registered readout beat.
REQ-017 dump_done  out  1  one-cycle pulse after the last readout beat.

Function
REQ-018 WB_write_data SHALL equal WB_mem_data when WB_mem_to_reg=1, else WB_alu_result.
REQ-019 On a rising edge with WB_reg_write=1 and WB_mux_out!=0, reg[WB_mux_out] SHALL take WB_write_data.
REQ-020 Register 0 SHALL never be written and SHALL always read 0.
REQ-021 Read ports SHALL return reg[index] combinationally, with zero-cycle read latency.
REQ-022 Bypass: if WB_reg_write=1, WB_mux_out!=0 and WB_mux_out equals a read index, that port SHALL return WB_write_data in the same cycle.
REQ-023 rs and rt SHALL bypass independently; the same index on both ports SHALL return identical data.
REQ-024 retire_count SHALL increment by 1 on every edge with WB_reg_write=1, including writes to index 0.
REQ-025 retire_count SHALL wrap from 0xFFFFFFFF to 0 without any flag.
REQ-026 Dump FSM states SHALL be IDLE and SCAN, with an internal ADDR_W index counter.
REQ-027 IDLE: on an edge with dump_req=1, the FSM SHALL move to SCAN with index=0, and dump_busy SHALL go high from that edge.
REQ-028 SCAN: on each edge, the block SHALL register dump_valid=1, dump_addr=index and dump_data=reg[index], with REQ-022 bypass against the same-cycle write, then increment index.
REQ-029 SCAN: the edge that registers index=2^ADDR_W-1 SHALL return the FSM to IDLE, and on the following edge dump_done SHALL pulse 1 for one cycle, with dump_valid=0 and dump_busy=0.
REQ-030 dump_req SHALL be ignored during SCAN and during the dump_done cycle; the block SHALL NOT queue it.
REQ-031 In IDLE, dump_valid SHALL be 0; dump_addr and dump_data SHALL hold their last values.
REQ-032 Write-back and read ports SHALL operate normally during SCAN, and the readout SHALL NOT stall the pipeline.

Reset
REQ-033 On an edge with startin_n=0, all registers, retire_count, dump_addr and dump_data SHALL be cleared to 0.
REQ-034 On the same edge, the FSM SHALL go to IDLE with index=0, and dump_busy, dump_valid and dump_done SHALL be 0.
REQ-035 Reset SHALL take priority over a simultaneous write or dump_req, and a reset during SCAN SHALL abort the readout with no dump_done pulse.
REQ-036 After reset, all read ports SHALL return 0 until the first write.

Verification
REQ-037 Write 0xDEADBEEF (alu, mem_to_reg=0) to index 5, then read rs=5 -> ID_rs_data=0xDEADBEEF; write 0x1234 to index 0 -> reading index 0 returns 0 and retire_count increments.
REQ-038 Bypass: WB_reg_write=1, WB_mux_out=7, mem_to_reg=1, mem_data=0xA5A5A5A5, with rs=rt=7 in the same cycle -> both ports return 0xA5A5A5A5 before the edge.
REQ-039 Preload reg[k]=k*3 for k=1..31 and pulse dump_req -> 32 consecutive beats, addr 0..31, data 0,3,...,93, then dump_done pulses exactly once; a second dump_req mid-scan has no effect.
REQ-040 During SCAN, write 0x55 to index 10 on the cycle index=10 is registered -> beat 10 carries 0x55.
REQ-041 Preset retire_count=0xFFFFFFFE and issue 3 write-back cycles -> counts 0xFFFFFFFF, 0, 1.
REQ-042 Assert startin_n=0 at beat 12 of a scan -> outputs clear, no dump_done pulse, all registers read 0 afterwards.
